// File: rtl/bp_if_queue_pkg.sv
// rtl/bp_if_queue_pkg.sv - shared bus/branch widths and BP->IF entry layout
package bp_if_queue_pkg;

    // Default fetch address bus and global-history widths shared with BP and IF.
    localparam int BP_ADDR_BUS_WIDTH = 32;
    localparam int BP_GHR_WIDTH      = 5;

    // Entry packing order is {taken, pht_index, pc}, taken in the MSB.
    localparam int BP_ENTRY_WIDTH = 1 + BP_GHR_WIDTH + BP_ADDR_BUS_WIDTH;

    // Width of one queue entry for arbitrary address/history widths.
    function automatic int bp_entry_width(input int addr_w, input int ghr_w);
        return 1 + ghr_w + addr_w;
    endfunction

endpackage

// File: rtl/bp_queue_storage.sv
// rtl/bp_queue_storage.sv - entry register array, one sync write port, one async read port
module bp_queue_storage #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 38,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Data carries no reset; stale entries are hidden by the occupancy logic.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bp_if_queue.sv
// rtl/bp_if_queue.sv - DEPTH-entry decoupling FIFO between branch prediction and fetch
module bp_if_queue
    import bp_if_queue_pkg::*;
#(
    parameter int ADDR_WIDTH        = BP_ADDR_BUS_WIDTH,
    parameter int GHR_WIDTH         = BP_GHR_WIDTH,
    parameter int DEPTH             = 4,
    parameter int ALMOST_FULL_LEVEL = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_taken,
    input  logic [GHR_WIDTH-1:0]       in_pht_index,
    input  logic [ADDR_WIDTH-1:0]      in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_taken,
    output logic [GHR_WIDTH-1:0]       out_pht_index,
    output logic [ADDR_WIDTH-1:0]      out_pc,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = bp_entry_width(ADDR_WIDTH, GHR_WIDTH);

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   occ;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    // Handshakes come only from registered occupancy, so no in->out combinational path.
    assign in_ready    = (occ != CNT_W'(DEPTH));
    assign out_valid   = (occ != '0);
    assign push        = in_valid && in_ready;
    assign pop         = out_valid && out_ready;
    assign count       = occ;
    assign almost_full = (occ >= CNT_W'(ALMOST_FULL_LEVEL));
    assign wr_entry    = {in_taken, in_pht_index, in_pc};

    // Pointer and occupancy update; rst beats flush, flush beats push/pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                occ <= occ + CNT_W'(1);
            end else if (pop && !push) begin
                occ <= occ - CNT_W'(1);
            end
        end
    end

    bp_queue_storage #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .PTR_W (PTR_W)
    ) u_storage (
        .clk   (clk),
        .we    (push && !flush && !rst),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    // Head fields read as zero while the queue is empty.
    always_comb begin
        {out_taken, out_pht_index, out_pc} = '0;
        if (out_valid) begin
            {out_taken, out_pht_index, out_pc} = rd_entry;
        end
    end

endmodule
